// File: rtl/seq_array_mult.sv
// -----------------------------------------------------------------------------
// seq_array_mult
//
// Multi-cycle array multiplier. The WIDTH x WIDTH product is built from WIDTH
// partial-product rows, and ROWS of them are added into a 2*WIDTH-bit
// accumulator each cycle. The operands can be unsigned or two's-complement.
// In signed mode the multiplicand is sign-extended, and the row for the
// multiplier MSB is subtracted because that bit carries weight -2^(WIDTH-1).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds in_valid, a, b and signed_mode until it sees
// in_ready. The block holds out_valid and p until it sees out_ready.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     operand pair present
//   in_ready     block can accept operands (IDLE and not in reset)
//   a, b         WIDTH-bit multiplicand / multiplier
//   signed_mode  1 = two's-complement operands, sampled with a and b
//   out_valid    p holds a completed product (DONE)
//   out_ready    consumer accepts p
//   p            registered 2*WIDTH-bit product
// -----------------------------------------------------------------------------
module seq_array_mult #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;
    // Wide enough to hold WIDTH itself, which is the value after the last step.
    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sign_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    p_q;
    logic [KW-1:0]    k_q;

    logic             accept;
    logic             last_step;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [PW-1:0]    sum;

    assign p = p_q;

    // This step covers rows k .. k+ROWS-1, so it is the last one when it
    // reaches row WIDTH-1.
    assign last_step = (k_q + KW'(ROWS)) == KW'(WIDTH);

    // Control: next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                // in_ready is held low while reset is asserted.
                in_ready = !rst;
                if (in_valid && !rst) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath. Shifting b down by k and A_ext up by k lets the loop use
    // only constant row offsets j.
    always_comb begin
        a_ext = sign_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        a_sh  = a_ext << k_q;
        b_sh  = b_q >> k_q;
        sum   = acc_q;
        for (int j = 0; j < ROWS; j++) begin
            if (b_sh[j]) begin
                if (sign_q && (k_q == KW'(WIDTH - 1 - j)))
                    sum = sum - (a_sh << j);
                else
                    sum = sum + (a_sh << j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            k_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                sign_q <= signed_mode;
                acc_q  <= '0;
                k_q    <= '0;
            end else if (state_q == CALC) begin
                acc_q <= sum;
                k_q   <= k_q + KW'(ROWS);
                // p changes only when a product completes, so a partial sum
                // is never visible on the output.
                if (last_step) p_q <= sum;
            end
        end
    end

endmodule

// File: tb/tb_seq_array_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_array_mult
//
// Bench for seq_array_mult. Index 0 is WIDTH=8/ROWS=1, index 1 is
// WIDTH=8/ROWS=2 and index 2 is WIDTH=8/ROWS=8. All three share clk, rst,
// a, b and signed_mode. Each has its own handshake signals and product.
// -----------------------------------------------------------------------------
module tb_seq_array_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a, b;
    logic        sm;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    wire  [2:0]  ir;
    wire  [2:0]  ov;
    wire  [15:0] pp [3];

    int vectors   = 0;
    int errors    = 0;
    int accepted  = 0;
    int delivered = 0;

    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    seq_array_mult #(.WIDTH(8), .ROWS(1)) dut_r1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a), .b(b), .signed_mode(sm), .out_valid(ov[0]),
        .out_ready(ordy[0]), .p(pp[0]));

    seq_array_mult #(.WIDTH(8), .ROWS(2)) dut_r2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a), .b(b), .signed_mode(sm), .out_valid(ov[1]),
        .out_ready(ordy[1]), .p(pp[1]));

    seq_array_mult #(.WIDTH(8), .ROWS(8)) dut_r8 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a), .b(b), .signed_mode(sm), .out_valid(ov[2]),
        .out_ready(ordy[2]), .p(pp[2]));

    // One full transaction on instance idx: accept the operands, measure the
    // latency, hold the result for 'stall' cycles of backpressure, then hand
    // it off.
    task automatic do_op(input int idx, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ism, input logic [15:0] expp,
                         input int exp_lat, input int stall, input string name);
        int cyc;
        cyc = 0;
        while (ir[idx] !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        vectors++;
        if (ir[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready: got %b want 1", name, ir[idx]);
        end
        a = ia; b = ib; sm = ism;
        iv[idx]   = 1'b1;
        ordy[idx] = (stall == 0);
        @(posedge clk); #1;
        iv[idx] = 1'b0;
        accepted++;
        cyc = 0;
        while (ov[idx] !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        if (ov[idx] === 1'b1) delivered++;
        vectors++;
        if (cyc !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        vectors++;
        if (pp[idx] !== expp) begin
            errors++;
            $display("FAIL %s product: got %h want %h", name, pp[idx], expp);
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            vectors++;
            if (ov[idx] !== 1'b1 || pp[idx] !== expp) begin
                errors++;
                $display("FAIL %s hold: got valid=%b p=%h want valid=1 p=%h",
                         name, ov[idx], pp[idx], expp);
            end
        end
        ordy[idx] = 1'b1;
        @(posedge clk); #1;
        ordy[idx] = 1'b0;
        vectors++;
        if (ov[idx] !== 1'b0 || ir[idx] !== 1'b1) begin
            errors++;
            $display("FAIL %s handoff: got valid=%b ready=%b want valid=0 ready=1",
                     name, ov[idx], ir[idx]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        iv = '0; ordy = '0; a = '0; b = '0; sm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (ir[i] !== 1'b0 || ov[i] !== 1'b0 || pp[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset_%0d: got ready=%b valid=%b p=%h want 0 0 0000",
                         i, ir[i], ov[i], pp[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (ir[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_%0d: in_ready got %b want 1", i, ir[i]);
            end
        end
    endtask

    task automatic test_unsigned_max;
        do_op(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8, 0, "unsigned_max");
    endtask

    task automatic test_signed;
        do_op(0, 8'h80, 8'h80, 1'b1, 16'h4000, 8, 0, "signed_min_sq");
        do_op(0, 8'hFF, 8'h7F, 1'b1, 16'hFF81, 8, 1, "signed_m1_x_127");
        do_op(0, 8'h80, 8'h7F, 1'b1, 16'hC080, 8, 0, "signed_min_x_127");
        do_op(0, 8'h80, 8'h80, 1'b0, 16'h4000, 8, 0, "unsigned_80_80");
        do_op(0, 8'hFF, 8'h7F, 1'b0, 16'h7E81, 8, 2, "unsigned_ff_7f");
        do_op(0, 8'h7F, 8'hFF, 1'b1, 16'hFF81, 8, 0, "signed_127_x_m1");
    endtask

    task automatic test_backpressure;
        int cyc;
        ordy[0] = 1'b0;
        vectors++;
        if (ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_start_ready: got %b want 1", ir[0]);
        end
        a = 8'd13; b = 8'd11; sm = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        cyc = 0;
        while (ov[0] !== 1'b1 && cyc < 50) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            sm = 1'($urandom_range(0, 1));
            iv[0] = 1'($urandom_range(0, 1));
            @(posedge clk); #1; cyc++;
            vectors++;
            if (ir[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_calc_ready: got %b want 0", ir[0]);
            end
        end
        vectors++;
        if (pp[0] !== 16'd143 || cyc !== 8) begin
            errors++;
            $display("FAIL bp_result: got p=%0d lat=%0d want p=143 lat=8", pp[0], cyc);
        end
        for (int s = 0; s < 5; s++) begin
            iv[0] = 1'b1;
            a = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            vectors++;
            if (ov[0] !== 1'b1 || pp[0] !== 16'd143 || ir[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b p=%0d ready=%b want 1 143 0",
                         ov[0], pp[0], ir[0]);
            end
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        vectors++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_handoff: got valid=%b ready=%b want 0 1", ov[0], ir[0]);
        end
    endtask

    task automatic test_reset_mid;
        a = 8'hAA; b = 8'h55; sm = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (ov[0] !== 1'b0 || pp[0] !== 16'h0 || ir[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b p=%h ready=%b want 0 0000 0",
                     ov[0], pp[0], ir[0]);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_idle: in_ready got %b want 1", ir[0]);
        end
        ordy[0] = 1'b0;
        do_op(0, 8'd3, 8'd5, 1'b0, 16'd15, 8, 0, "after_reset");
    endtask

    task automatic test_rows;
        do_op(1, 8'd200, 8'd100, 1'b0, 16'd20000, 4, 0, "rows2_unsigned");
        do_op(2, 8'd200, 8'd100, 1'b0, 16'd20000, 1, 0, "rows8_unsigned");
        do_op(1, 8'h80, 8'h7F, 1'b1, 16'hC080, 4, 1, "rows2_signed");
        do_op(2, 8'h80, 8'h80, 1'b1, 16'h4000, 1, 1, "rows8_signed");
    endtask

    // Back-to-back random products on all three configurations, with random
    // output stalls. The reference is the bench's own multiply.
    task automatic test_back_to_back;
        logic [7:0]         ra, rb;
        logic               rs;
        logic signed [15:0] sa, sb;
        logic [15:0]        e;
        int                 lat [3];
        lat[0] = 8; lat[1] = 4; lat[2] = 1;
        accepted = 0;
        delivered = 0;
        for (int n = 0; n < 240; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            sa = {{8{ra[7]}}, ra};
            sb = {{8{rb[7]}}, rb};
            if (rs) e = 16'(sa * sb);
            else    e = 16'({8'h00, ra} * {8'h00, rb});
            exp_q.push_back(e);
            do_op(n % 3, ra, rb, rs, exp_q.pop_front(), lat[n % 3],
                  int'($urandom_range(0, 3)), "random");
        end
        vectors++;
        if (accepted !== delivered) begin
            errors++;
            $display("FAIL random_count: delivered %0d want %0d", delivered, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_rows();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
